poly_tx_filter: RTL and testbench

- Parametrised polyphase interpolating pulse-shaping filter for the transmitter; multi-channel (default 2, I/Q).
- Takes one binary symbol per channel per baud and emits OV_SAMP shaped samples per channel.
- Coefficient memory is loadable at run time; sits between the symbol source (PRBS/mapper) and the DAC/channel model.

---
 rtl/poly_tx_filter.sv | 147 ++++++++++++++
 tb/tb_poly_tx_filter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/poly_tx_filter.sv
// Polyphase interpolating pulse-shaping filter: one antipodal symbol per channel per baud
// in, OV_SAMP shaped samples per channel out, with run-time loadable shared coefficients.
module poly_tx_filter #(
  parameter int OV_SAMP    = 4,
  parameter int N_BAUD     = 6,
  parameter int N_CH       = 2,
  parameter int NB_COEFF   = 8,
  parameter int NBF_COEFF  = 7,
  parameter int NB_OUTPUT  = 8,
  parameter int NBF_OUTPUT = 7
) (
  input  logic                                      clk,
  input  logic                                      i_rst_n,
  input  logic                                      i_enb,
  input  logic                                      i_valid,
  output logic                                      o_ready,
  input  logic [N_CH-1:0]                           i_symbol,
  input  logic                                      i_coef_we,
  input  logic [$clog2(OV_SAMP*N_BAUD)-1:0]         i_coef_addr,
  input  logic [NB_COEFF-1:0]                       i_coef_data,
  output logic [N_CH*NB_OUTPUT-1:0]                 o_data,
  output logic                                      o_valid,
  output logic                                      o_underrun
);

  localparam int N_TAP  = OV_SAMP * N_BAUD;
  localparam int ADDR_W = $clog2(N_TAP);
  localparam int P_W    = $clog2(OV_SAMP);
  localparam int FILL_W = $clog2(N_BAUD + 1);
  localparam int NB_SUM = NB_COEFF + $clog2(N_BAUD) + 1;
  localparam int SHIFT  = NBF_COEFF - NBF_OUTPUT;

  localparam logic [P_W-1:0]           P_LAST   = P_W'(OV_SAMP - 1);
  localparam logic [FILL_W-1:0]        FILL_MAX = FILL_W'(N_BAUD);
  localparam logic signed [NB_SUM-1:0] SAT_MAX  = NB_SUM'((2 ** (NB_OUTPUT - 1)) - 1);
  localparam logic signed [NB_SUM-1:0] SAT_MIN  = NB_SUM'(-(2 ** (NB_OUTPUT - 1)));

  typedef enum logic {IDLE, RUN} state_t;

  state_t                        state_q, state_d;
  logic [P_W-1:0]                p_q, p_d;
  logic [FILL_W-1:0]             fill_q, fill_d;
  logic [N_BAUD-1:0]             hist_q [N_CH];
  logic [N_BAUD-1:0]             hist_d [N_CH];
  logic signed [NB_COEFF-1:0]    coef_q [N_TAP];
  logic signed [NB_COEFF-1:0]    coef_d [N_TAP];
  logic [N_CH*NB_OUTPUT-1:0]     data_q, data_d;
  logic                          valid_q, valid_d;
  logic                          underrun_q, underrun_d;

  logic                          accept;
  logic [N_CH*NB_OUTPUT-1:0]     sat_out;
  logic signed [NB_SUM-1:0]      acc, term, shifted;
  logic [ADDR_W-1:0]             idx;

  assign o_ready    = (state_q == IDLE) | ((state_q == RUN) & (p_q == P_LAST));
  assign accept     = i_valid & o_ready & i_enb;
  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_underrun = underrun_q;

  // Phase p of the current baud uses taps h[k*OV_SAMP+p]; taps beyond the fill count are masked.
  always_comb begin
    sat_out = '0;
    acc     = '0;
    term    = '0;
    shifted = '0;
    idx     = '0;
    for (int c = 0; c < N_CH; c++) begin
      acc = '0;
      for (int k = 0; k < N_BAUD; k++) begin
        idx  = ADDR_W'(k * OV_SAMP) + ADDR_W'(p_q);
        term = NB_SUM'(coef_q[idx]);
        if (FILL_W'(k) < fill_q) begin
          acc = hist_q[c][k] ? (acc - term) : (acc + term);
        end
      end
      shifted = acc >>> SHIFT;
      if (shifted > SAT_MAX) begin
        sat_out[c*NB_OUTPUT +: NB_OUTPUT] = SAT_MAX[NB_OUTPUT-1:0];
      end else if (shifted < SAT_MIN) begin
        sat_out[c*NB_OUTPUT +: NB_OUTPUT] = SAT_MIN[NB_OUTPUT-1:0];
      end else begin
        sat_out[c*NB_OUTPUT +: NB_OUTPUT] = shifted[NB_OUTPUT-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    fill_d     = fill_q;
    hist_d     = hist_q;
    coef_d     = coef_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    underrun_d = underrun_q;

    if (i_coef_we && (int'(i_coef_addr) < N_TAP)) begin
      coef_d[i_coef_addr] = i_coef_data;
    end

    if (i_enb) begin
      if (state_q == RUN) begin
        data_d  = sat_out;
        valid_d = 1'b1;
        if (p_q != P_LAST) begin
          p_d = p_q + 1'b1;
        end else if (!accept) begin
          state_d    = IDLE;
          underrun_d = 1'b1;
        end
      end
      if (accept) begin
        for (int c = 0; c < N_CH; c++) begin
          hist_d[c] = {hist_q[c][N_BAUD-2:0], i_symbol[c]};
        end
        fill_d  = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
        p_d     = '0;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      p_q        <= '0;
      fill_q     <= '0;
      hist_q     <= '{default: '0};
      coef_q     <= '{default: '0};
      data_q     <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      fill_q     <= fill_d;
      hist_q     <= hist_d;
      coef_q     <= coef_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_poly_tx_filter.sv
// Directed bench for poly_tx_filter with default parameters (4 phases, 6 taps/phase, I/Q).
module tb_poly_tx_filter;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_enb;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_symbol;
  logic        i_coef_we;
  logic [4:0]  i_coef_addr;
  logic [7:0]  i_coef_data;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_underrun;

  int checks = 0;
  int errors = 0;

  poly_tx_filter dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_enb       (i_enb),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_symbol    (i_symbol),
    .i_coef_we   (i_coef_we),
    .i_coef_addr (i_coef_addr),
    .i_coef_data (i_coef_data),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_underrun  (o_underrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic wr(input int a, input int d);
    i_coef_we   = 1'b1;
    i_coef_addr = 5'(a);
    i_coef_data = 8'(d);
    step();
    i_coef_we   = 1'b0;
  endtask

  task automatic pulse_reset();
    i_rst_n = 1'b0;
    #1;
    i_rst_n = 1'b1;
  endtask

  // Accept one symbol, then check phases 0..2; returns with p=3 and o_ready high.
  task automatic baud(input string tag, input logic [1:0] sym,
                      input logic [15:0] e0, input logic [15:0] e12);
    chk({tag, "_ready"}, 16'(o_ready), 16'h1);
    i_symbol = sym;
    i_valid  = 1'b1;
    step();
    i_valid  = 1'b0;
    for (int ph = 0; ph < 3; ph++) begin
      step();
      chk({tag, "_valid"}, 16'(o_valid), 16'h1);
      chk({tag, "_data"}, o_data, (ph == 0) ? e0 : e12);
    end
  endtask

  logic [15:0] exp_imp [8] = '{16'hC040, 16'h0000, 16'h0000, 16'h0000,
                               16'h4040, 16'hE020, 16'h0000, 16'h0000};
  int nval;

  initial begin
    i_rst_n     = 1'b0;
    i_enb       = 1'b1;
    i_valid     = 1'b0;
    i_symbol    = 2'b00;
    i_coef_we   = 1'b0;
    i_coef_addr = '0;
    i_coef_data = '0;
    #12;
    chk("rst_data", o_data, 16'h0000);
    chk("rst_valid", 16'(o_valid), 16'h0);
    chk("rst_underrun", 16'(o_underrun), 16'h0);
    chk("rst_ready", 16'(o_ready), 16'h1);
    step();
    i_rst_n = 1'b1;

    // Impulse followed by a seamless second baud, then underrun
    wr(0, 'h40);
    wr(5, 'h20);
    chk("imp_ready", 16'(o_ready), 16'h1);
    i_symbol = 2'b10;
    i_valid  = 1'b1;
    step();
    i_valid  = 1'b0;
    chk("imp_accept_valid", 16'(o_valid), 16'h0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        chk("b2b_ready", 16'(o_ready), 16'h1);
        i_symbol = 2'b00;
        i_valid  = 1'b1;
      end
      step();
      i_valid = 1'b0;
      chk("imp_valid", 16'(o_valid), 16'h1);
      chk("imp_data", o_data, exp_imp[i]);
      chk("imp_underrun", 16'(o_underrun), (i == 7) ? 16'h1 : 16'h0);
    end
    chk("udr_ready", 16'(o_ready), 16'h1);
    step();
    chk("udr_idle_valid", 16'(o_valid), 16'h0);
    chk("udr_idle_data", o_data, 16'h0000);
    chk("udr_sticky", 16'(o_underrun), 16'h1);

    // Saturation with all taps at 0x7F
    pulse_reset();
    chk("rst2_underrun", 16'(o_underrun), 16'h0);
    for (int a = 0; a < 24; a++) wr(a, 'h7F);
    for (int b = 0; b < 6; b++) baud("sat_pos", 2'b00, 16'h7F7F, 16'h7F7F);
    baud("sat_n1", 2'b11, 16'h7F7F, 16'h7F7F);
    baud("sat_n2", 2'b11, 16'h7F7F, 16'h7F7F);
    baud("sat_n3", 2'b11, 16'h0000, 16'h0000);
    baud("sat_n4", 2'b11, 16'h8080, 16'h8080);
    baud("sat_n5", 2'b11, 16'h8080, 16'h8080);
    baud("sat_n6", 2'b11, 16'h8080, 16'h8080);
    chk("sat_no_underrun", 16'(o_underrun), 16'h0);
    step();
    chk("sat_ph3_data", o_data, 16'h8080);
    chk("sat_end_underrun", 16'(o_underrun), 16'h1);

    // Accumulation without saturation, then enable stretch
    pulse_reset();
    for (int a = 0; a < 24; a++) wr(a, 'h10);
    baud("acc1", 2'b00, 16'h1010, 16'h1010);
    baud("acc2", 2'b00, 16'h2020, 16'h2020);
    baud("acc3", 2'b00, 16'h3030, 16'h3030);
    baud("acc4", 2'b00, 16'h4040, 16'h4040);
    chk("enb_ready", 16'(o_ready), 16'h1);
    i_symbol = 2'b00;
    i_valid  = 1'b1;
    step();
    i_valid  = 1'b0;
    nval = 0;
    step();
    if (o_valid) nval++;
    chk("enb_ph0_data", o_data, 16'h5050);
    i_enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("enb_off_valid", 16'(o_valid), 16'h0);
      chk("enb_off_data", o_data, 16'h5050);
      chk("enb_off_ready", 16'(o_ready), 16'h0);
    end
    i_enb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (o_valid) nval++;
      chk("enb_on_data", o_data, 16'h5050);
      chk("enb_on_underrun", 16'(o_underrun), (i == 2) ? 16'h1 : 16'h0);
    end
    chk("enb_sample_count", 16'(nval), 16'h4);

    // Exact negation of -128 and fill masking
    pulse_reset();
    wr(0, 'h80);
    wr(4, 'h30);
    baud("neg1", 2'b01, 16'h807F, 16'h0000);
    baud("neg2", 2'b00, 16'hB080, 16'h0000);
    step();
    chk("neg_ph3_data", o_data, 16'h0000);
    wr(24, 'h55);
    wr(31, 'h55);

    // Out-of-range writes leave taps unchanged; reset mid-baud at p=2
    chk("oor_ready", 16'(o_ready), 16'h1);
    i_symbol = 2'b00;
    i_valid  = 1'b1;
    step();
    i_valid  = 1'b0;
    step();
    chk("oor_ph0", o_data, 16'hB0B0);
    step();
    chk("oor_ph1", o_data, 16'h0000);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_data", o_data, 16'h0000);
    chk("mid_rst_valid", 16'(o_valid), 16'h0);
    chk("mid_rst_underrun", 16'(o_underrun), 16'h0);
    chk("mid_rst_ready", 16'(o_ready), 16'h1);
    @(negedge clk);
    i_rst_n = 1'b1;
    step();
    baud("post_rst", 2'b00, 16'h0000, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
